// File: rtl/uart_tx_queue_ctrl.sv
// Memory-mapped UART transmit queue: CPU writes bytes into a FIFO which is
// drained into the emitter through a valid/ready handshake.
module uart_tx_queue_ctrl #(
    parameter int DEPTH    = 16,
    parameter int DAT_BIT  = 1,
    parameter int CNTL_BIT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        io_sel,
    input  logic [29:0] io_wordaddr,
    input  logic        io_wstrb,
    input  logic        io_rstrb,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_data,
    output logic        uart_valid,
    input  logic        uart_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic          ovf_reg;
    state_t        state_reg;

    logic        push_req;
    logic        cntl_wr;
    logic        flush;
    logic        clr_ovf;
    logic        full;
    logic        empty;
    logic        handshake;
    logic        pop;
    logic        push_ok;
    logic        idle;
    logic [31:0] status;
    logic        unused_bits;

    assign push_req  = io_sel & io_wstrb & io_wordaddr[DAT_BIT];
    assign cntl_wr   = io_sel & io_wstrb & io_wordaddr[CNTL_BIT];
    assign flush     = cntl_wr & io_wdata[0];
    assign clr_ovf   = cntl_wr & io_wdata[1];
    assign full      = (count_reg == CNT_DEPTH);
    assign empty     = (count_reg == '0);
    assign handshake = (state_reg == SEND) & uart_valid & uart_ready;
    // A flush suppresses any pop so nothing new leaves a queue being cleared.
    assign pop       = ~empty & ~flush & ((state_reg == IDLE) | handshake);
    assign push_ok   = push_req & ~flush & (~full | pop);
    assign idle      = empty & (state_reg == IDLE);
    assign status    = {{(16-AW-1){1'b0}}, count_reg, 4'b0000, ovf_reg, idle, full, 9'b0};
    assign unused_bits = ^{io_wdata[31:8], io_wordaddr};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= io_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            state_reg  <= IDLE;
            io_rdata   <= '0;
            uart_data  <= '0;
            uart_valid <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                case ({push_ok, pop})
                    2'b10:   count_reg <= count_reg + CNT_ONE;
                    2'b01:   count_reg <= count_reg - CNT_ONE;
                    default: count_reg <= count_reg;
                endcase
            end

            if (push_req & ~flush & full & ~pop) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end

            if (io_sel & io_rstrb) begin
                io_rdata <= io_wordaddr[CNTL_BIT] ? status : 32'd0;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        uart_data <= mem[rd_ptr_reg];
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    uart_valid <= 1'b1;
                    state_reg  <= SEND;
                end
                SEND: begin
                    // The presented byte always completes, even across a flush.
                    if (handshake) begin
                        uart_valid <= 1'b0;
                        if (pop) begin
                            uart_data <= mem[rd_ptr_reg];
                            state_reg <= LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue_ctrl.sv
// Scoreboard bench for uart_tx_queue_ctrl: expected bytes are queued at push
// time and a negedge monitor checks every emitter handshake against them.
module tb_uart_tx_queue_ctrl;

    localparam logic [29:0] A_DAT  = 30'h2;
    localparam logic [29:0] A_CNTL = 30'h4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        io_sel = 1'b0;
    logic [29:0] io_wordaddr = '0;
    logic        io_wstrb = 1'b0;
    logic        io_rstrb = 1'b0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic [7:0]  uart_data;
    logic        uart_valid;
    logic        uart_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [31:0] st;
    logic done6;

    always #5 clk = ~clk;

    uart_tx_queue_ctrl dut (
        .clk(clk), .resetn(resetn), .io_sel(io_sel), .io_wordaddr(io_wordaddr),
        .io_wstrb(io_wstrb), .io_rstrb(io_rstrb), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .uart_data(uart_data), .uart_valid(uart_valid),
        .uart_ready(uart_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next posedge when valid&ready here.
    always @(negedge clk) begin
        if (resetn && uart_valid && uart_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %h, expected none", uart_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (uart_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %h, expected %h", uart_data, e);
                end else begin
                    $display("tx byte %h", uart_data);
                end
            end
        end
    end

    // All bus tasks start and end 1 time unit after a posedge.
    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        io_sel = 1'b1; io_wstrb = 1'b1; io_wordaddr = a; io_wdata = d;
        @(posedge clk); #1;
        io_sel = 1'b0; io_wstrb = 1'b0; io_wordaddr = '0; io_wdata = '0;
    endtask

    task automatic push(input logic [7:0] b, input bit expected);
        wr(A_DAT, {24'h0, b});
        if (expected) exp_q.push_back(b);
    endtask

    task automatic rd_status(output logic [31:0] v);
        io_sel = 1'b1; io_rstrb = 1'b1; io_wordaddr = A_CNTL;
        @(posedge clk); #1;
        v = io_rdata;
        io_sel = 1'b0; io_rstrb = 1'b0; io_wordaddr = '0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || uart_valid) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!uart_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_valid_seen"}, {31'h0, uart_valid}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_valid", {31'h0, uart_valid}, 32'h0);
        check("rst_data", {24'h0, uart_data}, 32'h0);
        check("rst_rdata", io_rdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rd_status(st);
        check("rst_status", st, 32'h0000_0400);

        // 1: push with ready high, valid two edges after the push edge
        uart_ready = 1'b1;
        push(8'h61, 1'b1);
        check("t1_valid_n0", {31'h0, uart_valid}, 32'h0);
        @(posedge clk); #1;
        check("t1_valid_n1", {31'h0, uart_valid}, 32'h0);
        @(posedge clk); #1;
        check("t1_valid_n2", {31'h0, uart_valid}, 32'h1);
        check("t1_data", {24'h0, uart_data}, 32'h61);
        @(posedge clk); #1;
        rd_status(st);
        check("t1_status_idle", st, 32'h0000_0400);

        // 2: byte 0x00 moves into the emitter slot, so 0x01..0x10 fill the queue
        uart_ready = 1'b0;
        for (int i = 0; i <= 16; i++) push(i[7:0], 1'b1);
        rd_status(st);
        check("t2_full", st, 32'h0010_0200);
        push(8'h11, 1'b0);
        rd_status(st);
        check("t2_ovf", st, 32'h0010_0A00);

        // 3: push on the same edge as a SEND pop while full
        wr(A_CNTL, 32'h2);
        uart_ready = 1'b1;
        push(8'h12, 1'b1);
        uart_ready = 1'b0;
        rd_status(st);
        check("t3_full_no_ovf", st, 32'h0010_0200);
        uart_ready = 1'b1;
        wait_drain("t3");

        // 4: flush with a byte presented; set and clear ovf around it
        uart_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h20 + i[7:0], i == 0);
        rd_status(st);
        check("t4_count4", st, 32'h0004_0000);
        for (int i = 5; i < 18; i++) push(8'h20 + i[7:0], 1'b0);
        wr(A_CNTL, 32'h1);
        rd_status(st);
        check("t4_flushed", st, 32'h0000_0800);
        wr(A_CNTL, 32'h2);
        rd_status(st);
        check("t4_ovf_clr", st, 32'h0000_0000);
        check("t4_data_held", {24'h0, uart_data}, 32'h20);
        uart_ready = 1'b1;
        wait_drain("t4");
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (uart_valid) seen++;
            end
            check("t4_no_more_valid", seen, 0);
        end
        rd_status(st);
        check("t4_idle", st, 32'h0000_0400);

        // 5: asynchronous reset while a byte is presented
        uart_ready = 1'b0;
        push(8'h55, 1'b0);
        wait_valid("t5");
        #3;
        resetn = 1'b0;
        #1;
        check("t5_async_valid", {31'h0, uart_valid}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rd_status(st);
        check("t5_status", st, 32'h0000_0400);

        // 6: 40 bytes through the queue with ready toggling
        done6 = 1'b0;
        fork
            begin
                while (!done6) begin
                    @(posedge clk); #1;
                    uart_ready = ~uart_ready;
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    push(8'h40 + i[7:0], 1'b1);
                    repeat (3) @(posedge clk);
                    #1;
                end
                done6 = 1'b1;
            end
        join
        uart_ready = 1'b1;
        wait_drain("t6");
        rd_status(st);
        check("t6_status", st, 32'h0000_0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
